// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the response bundle
// used by the command master and its response FIFO.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  // Oversized or unaligned requests never reach the bus
  function automatic logic misaligned(
    input logic [1:0] lsb,
    input logic [2:0] size
  );
    unique case (size)
      HSIZE_BYTE: return 1'b0;
      HSIZE_HALF: return lsb[0];
      HSIZE_WORD: return |lsb;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rsp_fifo.sv
// Synchronous response FIFO; head is the oldest entry,
// push and pop may happen together even when full.
module ahb_rsp_fifo
  import ahb_lite_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  rsp_t        push_data,
  input  logic        pop,
  output rsp_t        head,
  output logic [AW:0] count
);

  rsp_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single master: command stream in, pipelined
// NONSEQ transfers out, in-order responses via a FIFO.
module ahb_lite_cmd_master
  import ahb_lite_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam int OW = CW + 1;

  logic          a_valid;
  logic          a_write;
  logic [31:0]   a_wdata;
  logic          d_valid;
  logic          d_write;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] occ;
  logic          bad;
  logic          all_empty;
  logic          accept;
  logic          issue;
  logic          push;
  logic          pop;
  rsp_t          push_data;
  rsp_t          head;

  assign bad       = misaligned(cmd_addr[1:0], cmd_size);
  assign occ       = OW'(fifo_count) + OW'(a_valid) + OW'(d_valid);
  assign all_empty = !a_valid && !d_valid && (fifo_count == '0);

  // A local error bypasses the bus, so only let it in
  // when nothing older could still be ahead of it
  assign cmd_ready = HREADY &&
                     (bad ? all_empty : (occ < OW'(RSP_DEPTH)));
  assign accept    = cmd_valid && cmd_ready;
  assign issue     = accept && !bad;
  assign push      = HREADY && (d_valid || (accept && bad));
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    push_data = '0;
    if (d_valid) begin
      push_data.write = d_write;
      push_data.rdata = d_write ? 32'd0 : HRDATA;
      push_data.err   = (HRESP != HRESP_OKAY);
    end else begin
      push_data.write = cmd_write;
      push_data.err   = HRESP_ERROR;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_wdata <= '0;
      HADDR   <= '0;
      HSIZE   <= '0;
      d_valid <= 1'b0;
      d_write <= 1'b0;
      HWDATA  <= '0;
    end else if (HREADY) begin
      d_valid <= a_valid;
      d_write <= a_write;
      HWDATA  <= a_wdata;
      a_valid <= issue;
      if (issue) begin
        a_write <= cmd_write;
        a_wdata <= cmd_wdata;
        HADDR   <= cmd_addr;
        HSIZE   <= cmd_size;
      end
    end
  end

  assign HWRITE = a_write;
  assign HTRANS = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;

  ahb_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_fifo (
    .clk      (HCLK),
    .rst      (HRESET),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  assign rsp_valid = (fifo_count != '0);
  assign rsp_write = rsp_valid ? head.write : 1'b0;
  assign rsp_rdata = rsp_valid ? head.rdata : 32'd0;
  assign rsp_err   = rsp_valid ? head.err   : 1'b0;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Self-checking bench: directed scenarios plus random
// traffic against a transaction-level response model.
module tb_ahb_lite_cmd_master;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run_len = 0;
  int max_run = 0;

  logic [33:0] exp_q [$];
  logic [31:0] mmem [64];
  logic [31:0] smem [64];

  ahb_lite_cmd_master #(.RSP_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc++;

  // Zero-wait memory slave; word 0x80 answers ERROR
  logic        dp_valid;
  logic        dp_write;
  logic [31:0] dp_addr;
  logic        dp_err;
  assign dp_err = (dp_addr[31:2] == 30'h20);
  assign HRESP  = dp_valid && dp_err;
  assign HRDATA = (dp_valid && !dp_write && !dp_err) ?
                  smem[dp_addr[7:2]] : 32'd0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
    end else if (HREADY) begin
      if (dp_valid && dp_write && !dp_err)
        smem[dp_addr[7:2]] = HWDATA;
      dp_valid <= (HTRANS == 2'b10);
      dp_addr  <= HADDR;
      dp_write <= HWRITE;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Expected response {write, rdata, err} from the rules
  function automatic logic [33:0] model_rsp(
    input logic w, input logic [31:0] a,
    input logic [2:0] s, input logic [31:0] d);
    int unsigned bytes;
    logic berr;
    if (s > 3'd2) return {w, 32'd0, 1'b1};
    bytes = 1 << s;
    if ((a % bytes) != 0) return {w, 32'd0, 1'b1};
    berr = (a[31:2] == 30'h20);
    if (w) begin
      if (!berr) mmem[a[7:2]] = d;
      return {1'b1, 32'd0, berr};
    end
    return {1'b0, berr ? 32'd0 : mmem[a[7:2]], berr};
  endfunction

  always @(negedge HCLK) begin
    if (HRESET) begin
      exp_q.delete();
      run_len = 0;
    end else begin
      run_len = rsp_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (rsp_valid && rsp_ready) begin
        chk("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          chk("rsp", {rsp_write, rsp_rdata, rsp_err},
              exp_q.pop_front());
      end
      if (cmd_valid && cmd_ready)
        exp_q.push_back(model_rsp(cmd_write, cmd_addr,
                                  cmd_size, cmd_wdata));
    end
  end

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [2:0] s, input logic [31:0] d,
                      input bit rnd);
    bit done = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge HCLK);
      done = cmd_ready;
      @(posedge HCLK);
      #1;
      if (rnd) begin
        HREADY    = ($urandom_range(0, 3) != 0);
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    cmd_valid = 1'b0;
    chk("send_accepted", done, 1);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge HCLK);
      #1;
      done = (exp_q.size() == 0) && !rsp_valid &&
             (HTRANS == 2'b00);
    end
    chk("drain", done, 1);
  endtask

  initial begin
    int acc;
    int t0;
    int seen;
    bit got;
    logic [2:0]  s;
    logic [31:0] a;

    for (int i = 0; i < 64; i++) begin
      smem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
      mmem[i] = smem[i];
    end
    HRESET = 1'b1; HREADY = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = '0; cmd_wdata = '0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwrite", HWRITE, 0);
    chk("rst_hsize", HSIZE, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_err}, 0);
    @(posedge HCLK); #1;
    HRESET = 1'b0; HREADY = 1'b0;
    @(negedge HCLK);
    chk("ready_follows_low", cmd_ready, 0);
    @(posedge HCLK); #1;
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("ready_follows_high", cmd_ready, 1);

    // Write then read back, cycle exact
    @(posedge HCLK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10;
    cmd_size = 3'd2; cmd_wdata = 32'hCAFE_F00D;
    @(negedge HCLK);
    chk("wr_ready", cmd_ready, 1);
    @(posedge HCLK); #1;
    cmd_write = 1'b0; cmd_wdata = 32'd0;
    @(negedge HCLK);
    chk("n1_ctrl", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b1, 32'h10});
    @(posedge HCLK); #1;
    cmd_valid = 1'b0;
    @(negedge HCLK);
    chk("n2_ctrl", {HTRANS, HWRITE, HADDR}, {2'b10, 1'b0, 32'h10});
    chk("n2_hwdata", HWDATA, 32'hCAFE_F00D);
    @(negedge HCLK);
    chk("n3_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_err},
        {1'b1, 1'b1, 32'd0, 1'b0});
    @(negedge HCLK);
    chk("n4_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_err},
        {1'b1, 1'b0, 32'hCAFE_F00D, 1'b0});
    wait_drain();

    // Back-to-back reads, one per cycle
    @(posedge HCLK); #1;
    max_run = 0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) send(1'b0, 32'(i * 4), 3'd2, 0, 0);
    chk("b2b_cycles", cyc - t0, 8);
    wait_drain();
    chk("b2b_rsp_run", max_run, 8);

    // Wait states during transfer 2 of 3
    @(posedge HCLK); #1;
    send(1'b0, 32'h20, 3'd2, 0, 0);
    send(1'b0, 32'h24, 3'd2, 0, 0);
    HREADY = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0;
    cmd_addr = 32'h28; cmd_size = 3'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk("ws_hold", {HTRANS, HADDR}, {2'b10, 32'h24});
      chk("ws_ready", cmd_ready, 0);
      chk("ws_nopush", rsp_valid, 0);
      @(posedge HCLK); #1;
    end
    cmd_valid = 1'b0;
    HREADY = 1'b1;
    send(1'b0, 32'h28, 3'd2, 0, 0);
    wait_drain();

    // Response backpressure caps occupancy
    @(posedge HCLK); #1;
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_size = 3'd2;
      cmd_addr = 32'h40 + 32'(acc * 4);
      @(negedge HCLK);
      if (cmd_ready) acc++;
      @(posedge HCLK); #1;
    end
    chk("bp_accepted", acc, 4);
    @(negedge HCLK);
    chk("bp_ready", cmd_ready, 0);
    @(posedge HCLK); #1;
    rsp_ready = 1'b1;
    send(1'b0, 32'h50, 3'd2, 0, 0);
    send(1'b0, 32'h54, 3'd2, 0, 0);
    wait_drain();

    // Local alignment error never reaches the bus
    @(posedge HCLK); #1;
    send(1'b0, 32'h3, 3'd2, 0, 0);
    @(negedge HCLK);
    chk("lerr_idle", HTRANS, 2'b00);
    chk("lerr_rsp", {rsp_valid, rsp_write, rsp_rdata, rsp_err},
        {1'b1, 1'b0, 32'd0, 1'b1});
    wait_drain();
    @(posedge HCLK); #1;
    send(1'b0, 32'h30, 3'd2, 0, 0);
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'h31; cmd_size = 3'd1;
    @(negedge HCLK);
    chk("lerr_blocked", cmd_ready, 0);
    @(posedge HCLK); #1;
    send(1'b1, 32'h31, 3'd1, 32'h1234, 0);
    wait_drain();

    // Slave ERROR response
    @(posedge HCLK); #1;
    send(1'b0, 32'h80, 3'd2, 0, 0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge HCLK);
      got = rsp_valid;
    end
    chk("berr_err", {got, rsp_err}, 2'b11);
    wait_drain();

    // Random traffic with random stalls and backpressure
    @(posedge HCLK); #1;
    for (int n = 0; n < 60; n++) begin
      s = 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 35) * 4);
      if (s == 3'd0) a = a + 32'($urandom_range(0, 3));
      if (s == 3'd1) a = a + 32'($urandom_range(0, 1) * 2);
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) s = 3'($urandom_range(3, 7));
      send(1'($urandom_range(0, 1)), a, s, $urandom, 1);
    end
    HREADY = 1'b1;
    rsp_ready = 1'b1;
    wait_drain();

    // Reset with two in flight and one buffered
    @(posedge HCLK); #1;
    rsp_ready = 1'b0;
    send(1'b0, 32'h0, 3'd2, 0, 0);
    send(1'b0, 32'h4, 3'd2, 0, 0);
    send(1'b0, 32'h8, 3'd2, 0, 0);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("pre_rst_state", {rsp_valid, HTRANS}, {1'b1, 2'b10});
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("post_rst_state", {rsp_valid, HTRANS}, 3'b000);
    rsp_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge HCLK);
      if (rsp_valid || HTRANS != 2'b00) seen++;
    end
    chk("post_rst_quiet", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
